// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, default
// reset PC, sequential increment and the word-alignment helper.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request presented to instruction memory
        S_WAIT = 2'd1,  // request accepted, response outstanding
        S_HOLD = 2'd2   // instruction buffered for decode
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instruction, pc} holding register between the memory
// response and decode.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture inst_i/pc_i and mark the entry valid
//   flush_i      : drop the entry (consumed or wrong path)
//   inst_i, pc_i : incoming instruction word and its PC
//   valid_o      : entry holds a live instruction
//   inst_o, pc_o : buffered instruction word and PC
module fetch_hold_buf
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    // Flush only clears valid; the data stays put so the outputs do not
    // toggle needlessly while nothing is presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, issues one word fetch at a time to
// instruction memory and hands {instruction, pc} to decode. A redirect
// from the jump unit overrides everything and discards wrong-path work.
//   clk, rst                       : clock, synchronous active-high reset
//   jump_taken, jump_target        : redirect request and address
//   imem_req_valid/ready/addr      : fetch request channel
//   imem_resp_valid/data           : fetch response (no back-pressure)
//   inst_valid/ready, inst_out/pc  : decode handshake and payload
//   misalign_err                   : pulse after a redirect to a non-word address
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         drop_q, drop_d;
    logic         misalign_q, misalign_d;

    logic         req_fire;
    logic         buf_valid;
    logic         buf_load;
    logic         buf_flush;

    assign imem_req_valid = (state_q == S_REQ) & ~rst;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign buf_load  = ~jump_taken & (state_q == S_WAIT) & imem_resp_valid & ~drop_q;
    assign buf_flush = (state_q == S_HOLD) & (jump_taken | inst_ready);

    // Same-cycle jump gating keeps a younger instruction from reaching
    // decode while the jump unit is redirecting.
    assign inst_valid   = buf_valid & ~jump_taken & ~rst;
    assign misalign_err = misalign_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        misalign_d = 1'b0;

        if (jump_taken) begin
            fetch_pc_d = word_align(jump_target);
            misalign_d = (jump_target[1:0] != 2'b00);
            unique case (state_q)
                S_REQ: begin
                    // An accepted request still returns a response that
                    // must be swallowed.
                    if (req_fire) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD: state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            state_d = S_REQ;
                            drop_d  = 1'b0;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_pc_d = fetch_pc_q + PC_INC;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (buf_load),
        .flush_i (buf_flush),
        .inst_i  (imem_resp_data),
        .pc_i    (fetch_pc_q),
        .valid_o (buf_valid),
        .inst_o  (inst_out),
        .pc_o    (inst_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        misalign_err;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .jump_taken      (jump_taken),
        .jump_target     (jump_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_hs     = 0;

    // Memory model state
    logic        outst    = 1'b0;
    logic [31:0] saddr    = 32'h0;
    int          lat      = 0;
    int          lat_max  = 0;
    logic        resp_en  = 1'b1;
    logic        stall_en = 1'b0;
    logic [31:0] stall_addr = 32'h0;

    // Reference model: the next PC decode should see
    logic [31:0] model_pc = 32'h0;
    logic        exp_mis  = 1'b0;

    // Samples taken each cycle
    logic        s_req_v, s_inst_v, s_mis, s_fire;
    logic [31:0] s_addr, s_out, s_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic irdy, input logic mrdy,
                        input logic jt, input logic [31:0] tgt);
        logic nxt_mis;
        @(posedge clk);
        #1;
        rst         = r;
        jump_taken  = jt;
        jump_target = tgt;
        inst_ready  = irdy;
        imem_resp_valid = !r && outst && (lat == 0) && resp_en;
        imem_resp_data  = imem_resp_valid ? memf(saddr) : $urandom;
        imem_req_ready  = mrdy && !(stall_en && imem_req_addr == stall_addr);
        @(negedge clk);
        s_req_v  = imem_req_valid;
        s_addr   = imem_req_addr;
        s_inst_v = inst_valid;
        s_out    = inst_out;
        s_pc     = inst_pc;
        s_mis    = misalign_err;
        s_fire   = imem_req_valid && imem_req_ready;
        if (r) begin
            chk("rst_gate", {30'h0, s_req_v, s_inst_v}, 32'h0);
            model_pc = 32'h0;
            exp_mis  = 1'b0;
            outst    = 1'b0;
        end else begin
            chk("misalign", {31'h0, s_mis}, {31'h0, exp_mis});
            if (jt) chk("inst_v_in_redirect", {31'h0, s_inst_v}, 32'h0);
            if (s_req_v) chk("req_aligned", {30'h0, s_addr[1:0]}, 32'h0);
            if (s_inst_v && irdy) begin
                chk("dec_pc", s_pc, model_pc);
                chk("dec_inst", s_out, memf(model_pc));
                model_pc = model_pc + 32'd4;
                n_hs++;
            end
            nxt_mis = 1'b0;
            if (jt) begin
                model_pc = tgt & 32'hFFFF_FFFC;
                nxt_mis  = (tgt[1:0] != 2'b00);
            end
            exp_mis = nxt_mis;
            if (imem_resp_valid) outst = 1'b0;
            else if (outst && resp_en && lat > 0) lat--;
            if (s_fire) begin
                chk("one_outstanding", {31'h0, outst}, 32'h0);
                outst = 1'b1;
                saddr = s_addr;
                lat   = $urandom_range(0, lat_max);
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic        rst;
        logic        irdy;
        logic        jt;
        logic [31:0] tgt;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic        e_instv;
        logic        chkd;
        logic [31:0] e_out;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic irdy, input logic jt,
                                input logic [31:0] tgt, input logic reqv,
                                input logic [31:0] addr, input logic instv,
                                input logic chkd, input logic [31:0] out,
                                input logic [31:0] pc, input logic mis);
        vec_t v;
        v.rst = r; v.irdy = irdy; v.jt = jt; v.tgt = tgt;
        v.e_reqv = reqv; v.e_addr = addr; v.e_instv = instv;
        v.chkd = chkd; v.e_out = out; v.e_pc = pc; v.e_mis = mis;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        logic found;
        int   cnt;
        rst = 1'b1; jump_taken = 1'b0; jump_target = 32'h0; inst_ready = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

        // Reset release, back-pressure, misaligned redirect in S_HOLD
        tbl[0]  = mk(1, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h0,        32'h0,  0);
        tbl[1]  = mk(0, 1, 0, 32'h0,  1, 32'h0,  0, 0, 32'h0,        32'h0,  0);
        tbl[2]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,        32'h0,  0);
        tbl[3]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 32'h13,       32'h0,  0);
        tbl[4]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 32'h13,       32'h0,  0);
        tbl[5]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 32'h13,       32'h0,  0);
        tbl[6]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 32'h13,       32'h0,  0);
        tbl[7]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 32'h13,       32'h0,  0);
        tbl[8]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  1, 1, 32'h13,       32'h0,  0);
        tbl[9]  = mk(0, 1, 0, 32'h0,  1, 32'h4,  0, 0, 32'h0,        32'h0,  0);
        tbl[10] = mk(0, 1, 0, 32'h0,  0, 32'h4,  0, 0, 32'h0,        32'h0,  0);
        tbl[11] = mk(0, 1, 1, 32'h42, 0, 32'h4,  0, 1, memf(32'h4),  32'h4,  0);
        tbl[12] = mk(0, 1, 0, 32'h0,  1, 32'h40, 0, 0, 32'h0,        32'h0,  1);
        tbl[13] = mk(0, 1, 0, 32'h0,  0, 32'h40, 0, 0, 32'h0,        32'h0,  0);
        tbl[14] = mk(0, 1, 0, 32'h0,  0, 32'h40, 1, 1, memf(32'h40), 32'h40, 0);
        tbl[15] = mk(0, 1, 0, 32'h0,  1, 32'h44, 0, 0, 32'h0,        32'h0,  0);

        lat_max = 0;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].irdy, 1'b1, tbl[i].jt, tbl[i].tgt);
            chk($sformatf("t%0d_req_valid", i), {31'h0, s_req_v}, {31'h0, tbl[i].e_reqv});
            chk($sformatf("t%0d_req_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("t%0d_inst_valid", i), {31'h0, s_inst_v}, {31'h0, tbl[i].e_instv});
            chk($sformatf("t%0d_misalign", i), {31'h0, s_mis}, {31'h0, tbl[i].e_mis});
            if (tbl[i].chkd) begin
                chk($sformatf("t%0d_inst_out", i), s_out, tbl[i].e_out);
                chk($sformatf("t%0d_inst_pc", i), s_pc, tbl[i].e_pc);
            end
        end

        // Redirect in S_WAIT while the fetch of 0x8 is outstanding
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_fire && s_addr == 32'h8) found = 1'b1;
        end
        chk("wait_fetch8", {31'h0, found}, 32'h1);
        resp_en = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        resp_en = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("drop8_inst_valid", {31'h0, s_inst_v}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir100_req_valid", {31'h0, s_req_v}, 32'h1);
        chk("redir100_req_addr", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_inst_v) begin
                found = 1'b1;
                chk("redir100_inst_pc", s_pc, 32'h100);
            end
        end
        chk("redir100_seen", {31'h0, found}, 32'h1);

        // Redirect coinciding with the request handshake at 0x10
        do_reset();
        stall_en = 1'b1; stall_addr = 32'h10;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req_v && s_addr == 32'h10) found = 1'b1;
        end
        chk("reach_req10", {31'h0, found}, 32'h1);
        stall_en = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        chk("req10_fire", {31'h0, s_fire}, 32'h1);
        chk("req10_addr", s_addr, 32'h10);
        found = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_inst_v) cnt++;
            if (s_req_v) found = 1'b1;
        end
        chk("req200_seen", {31'h0, found}, 32'h1);
        chk("req200_addr", s_addr, 32'h200);
        chk("stale_inst_count", cnt, 32'h0);

        // PC wrap past the top of the address space
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_inst_v) begin
                found = 1'b1;
                chk("wrap_inst_pc", s_pc, 32'hFFFF_FFFC);
            end
        end
        chk("wrap_inst_seen", {31'h0, found}, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req_v) begin
                found = 1'b1;
                chk("wrap_req_addr", s_addr, 32'h0);
            end
        end
        chk("wrap_req_seen", {31'h0, found}, 32'h1);

        // Reset asserted while a fetch is outstanding
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("req300_addr", s_addr, 32'h300);
        chk("req300_fire", {31'h0, s_fire}, 32'h1);
        resp_en = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wait300_req_valid", {31'h0, s_req_v}, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        resp_en = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_rst_req_valid", {31'h0, s_req_v}, 32'h1);
        chk("post_rst_req_addr", s_addr, 32'h0);
        chk("post_rst_misalign", {31'h0, s_mis}, 32'h0);

        // Randomized traffic against the transaction-level model
        lat_max = 2;
        n_hs = 0;
        for (int i = 0; i < 4000; i++) begin
            logic        r, jt, irdy, mrdy;
            logic [31:0] tgt;
            r    = ($urandom_range(0, 249) == 0);
            jt   = !r && ($urandom_range(0, 11) == 0);
            tgt  = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
            irdy = ($urandom_range(0, 9) < 7);
            mrdy = ($urandom_range(0, 9) < 7);
            step(r, irdy, mrdy, jt, tgt);
        end
        chk("random_progress", {31'h0, (n_hs > 200)}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
